// File: rtl/jtag_tdo_capture_if.sv
// JTAG monitor bus: generator/chip pins in, reconstructed scan data out.
// Both ends must share the same DR_MAX_W and IR_W.
interface jtag_tdo_capture_if #(
  parameter int DR_MAX_W = 64,
  parameter int IR_W     = 4
);
  logic                trstn;
  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                cap_en;
  logic [3:0]          tap_state;
  logic [IR_W-1:0]     ir_value;
  logic                ir_valid;
  logic [DR_MAX_W-1:0] dr_tdi;
  logic [DR_MAX_W-1:0] dr_tdo;
  logic [6:0]          dr_len;
  logic                dr_valid;
  logic                overflow;

  modport master (
    output trstn, tms, tdi, tdo, cap_en,
    input  tap_state, ir_value, ir_valid,
    input  dr_tdi, dr_tdo, dr_len,
    input  dr_valid, overflow
  );

  modport slave (
    input  trstn, tms, tdi, tdo, cap_en,
    output tap_state, ir_value, ir_valid,
    output dr_tdi, dr_tdo, dr_len,
    output dr_valid, overflow
  );
endinterface

// File: rtl/jtag_tdo_capture.sv
// Passive TAP replay: tracks state from trstn/tms and
// rebuilds each IR/DR scan, pulsing valid in the Update cycle.
module jtag_tdo_capture #(
  parameter int             DR_MAX_W = 64,
  parameter int             IR_W     = 4,
  parameter logic [IR_W-1:0] IR_RESET = 4'b0010
) (
  input logic              jtag_clk_i,
  input logic              rst_n,
  jtag_tdo_capture_if.slave bus
);

  localparam int         AW   = $clog2(DR_MAX_W);
  localparam logic [6:0] MAXC = 7'(DR_MAX_W);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6,
    SH_DR  = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0,
    UPD_DR = 4'h5, SEL_IR = 4'h4,
    CAP_IR = 4'hE, SH_IR  = 4'hA,
    EX1_IR = 4'h9, PAU_IR = 4'hB,
    EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_e;

  tap_e                state;
  tap_e                nxt;
  logic [IR_W-1:0]     ir_value;
  logic [IR_W-1:0]     ir_sh;
  logic                ir_valid;
  logic [DR_MAX_W-1:0] sh_tdi;
  logic [DR_MAX_W-1:0] sh_tdo;
  logic [DR_MAX_W-1:0] dr_tdi;
  logic [DR_MAX_W-1:0] dr_tdo;
  logic [6:0]          cnt;
  logic [6:0]          dr_len;
  logic                ovf_int;
  logic                dr_valid;
  logic                overflow;

  // IEEE 1149.1 next-state graph driven by the sampled tms
  always_comb begin
    nxt = state;
    unique case (state)
      TLR:    nxt = bus.tms ? TLR    : RTI;
      RTI:    nxt = bus.tms ? SEL_DR : RTI;
      SEL_DR: nxt = bus.tms ? SEL_IR : CAP_DR;
      CAP_DR: nxt = bus.tms ? EX1_DR : SH_DR;
      SH_DR:  nxt = bus.tms ? EX1_DR : SH_DR;
      EX1_DR: nxt = bus.tms ? UPD_DR : PAU_DR;
      PAU_DR: nxt = bus.tms ? EX2_DR : PAU_DR;
      EX2_DR: nxt = bus.tms ? UPD_DR : SH_DR;
      UPD_DR: nxt = bus.tms ? SEL_DR : RTI;
      SEL_IR: nxt = bus.tms ? TLR    : CAP_IR;
      CAP_IR: nxt = bus.tms ? EX1_IR : SH_IR;
      SH_IR:  nxt = bus.tms ? EX1_IR : SH_IR;
      EX1_IR: nxt = bus.tms ? UPD_IR : PAU_IR;
      PAU_IR: nxt = bus.tms ? EX2_IR : PAU_IR;
      EX2_IR: nxt = bus.tms ? UPD_IR : SH_IR;
      UPD_IR: nxt = bus.tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end

  // TAP tracking, scan accumulation and Update-time output latching
  always_ff @(posedge jtag_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TLR;
      ir_value <= IR_RESET;
      ir_sh    <= '0;
      ir_valid <= 1'b0;
      sh_tdi   <= '0;
      sh_tdo   <= '0;
      cnt      <= '0;
      ovf_int  <= 1'b0;
      dr_tdi   <= '0;
      dr_tdo   <= '0;
      dr_len   <= '0;
      dr_valid <= 1'b0;
      overflow <= 1'b0;
    end else if (!bus.trstn) begin
      state    <= TLR;
      ir_value <= IR_RESET;
      ir_sh    <= '0;
      ir_valid <= 1'b0;
      sh_tdi   <= '0;
      sh_tdo   <= '0;
      cnt      <= '0;
      ovf_int  <= 1'b0;
      dr_valid <= 1'b0;
    end else begin
      state    <= nxt;
      ir_valid <= (nxt == UPD_IR);
      dr_valid <= (nxt == UPD_DR) && bus.cap_en;
      if (state == CAP_DR) begin
        sh_tdi  <= '0;
        sh_tdo  <= '0;
        cnt     <= '0;
        ovf_int <= 1'b0;
      end else if (state == SH_DR) begin
        if (cnt < MAXC) begin
          sh_tdi[cnt[AW-1:0]] <= bus.tdi;
          sh_tdo[cnt[AW-1:0]] <= bus.tdo;
          cnt <= cnt + 7'd1;
        end else begin
          ovf_int <= 1'b1;
        end
      end
      if (state == CAP_IR)
        ir_sh <= '0;
      else if (state == SH_IR)
        ir_sh <= {bus.tdi, ir_sh[IR_W-1:1]};
      if (nxt == UPD_IR)
        ir_value <= ir_sh;
      if (nxt == UPD_DR && bus.cap_en) begin
        dr_tdi   <= sh_tdi;
        dr_tdo   <= sh_tdo;
        dr_len   <= cnt;
        overflow <= ovf_int;
      end
      if (nxt == TLR) begin
        ir_value <= IR_RESET;
        ir_sh    <= '0;
        sh_tdi   <= '0;
        sh_tdo   <= '0;
        cnt      <= '0;
        ovf_int  <= 1'b0;
      end
    end
  end

  assign bus.tap_state = state;
  assign bus.ir_value  = ir_value;
  assign bus.ir_valid  = ir_valid;
  assign bus.dr_tdi    = dr_tdi;
  assign bus.dr_tdo    = dr_tdo;
  assign bus.dr_len    = dr_len;
  assign bus.dr_valid  = dr_valid;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_jtag_tdo_capture.sv
// Directed bench for jtag_tdo_capture: table-driven first DR scan,
// then hand-written IR, pause, overflow, cap_en and reset sequences.
module tb_jtag_tdo_capture;

  logic jtag_clk_i = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  jtag_tdo_capture_if #(.DR_MAX_W(64), .IR_W(4)) bus ();

  jtag_tdo_capture #(
    .DR_MAX_W(64),
    .IR_W(4),
    .IR_RESET(4'b0010)
  ) dut (
    .jtag_clk_i(jtag_clk_i),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 jtag_clk_i = ~jtag_clk_i;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic [3:0] st;
    logic       dv;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic di, input logic dout);
    @(negedge jtag_clk_i);
    bus.tms = t;
    bus.tdi = di;
    bus.tdo = dout;
    @(posedge jtag_clk_i);
    #1;
  endtask

  // Full DR scan from RTI back to RTI; checks the Update cycle.
  task automatic scan_dr(input logic [127:0] di,
                         input logic [127:0] dout,
                         input int n,
                         input logic expv);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < n; i++)
      step(i == n - 1, di[i], dout[i]);
    step(1, 0, 0);
    chk("scan_upd_state", 64'(bus.tap_state), 64'h5);
    chk("scan_dr_valid", 64'(bus.dr_valid), 64'(expv));
    step(0, 0, 0);
    chk("scan_dv_drop", 64'(bus.dr_valid), 64'h0);
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] c3;
    logic [127:0] ones;
    a5   = 8'hA5;
    c3   = 8'h3C;
    ones = '1;

    tbl[0] = '{0, 0, 0, 4'hC, 0};
    tbl[1] = '{1, 0, 0, 4'h7, 0};
    tbl[2] = '{0, 0, 0, 4'h6, 0};
    tbl[3] = '{0, 0, 0, 4'h2, 0};
    for (int i = 0; i < 8; i++)
      tbl[4+i] = '{(i == 7), a5[i], c3[i], (i == 7) ? 4'h1 : 4'h2, 0};
    tbl[12] = '{1, 0, 0, 4'h5, 1};
    tbl[13] = '{0, 0, 0, 4'hC, 0};

    rst_n      = 1'b0;
    bus.trstn  = 1'b1;
    bus.tms    = 1'b1;
    bus.tdi    = 1'b0;
    bus.tdo    = 1'b0;
    bus.cap_en = 1'b1;
    repeat (2) @(posedge jtag_clk_i);
    #1;
    chk("rst_state", 64'(bus.tap_state), 64'hF);
    chk("rst_ir", 64'(bus.ir_value), 64'h2);
    chk("rst_dr_tdi", bus.dr_tdi, 64'h0);
    chk("rst_dr_len", 64'(bus.dr_len), 64'h0);
    chk("rst_valids", 64'({bus.dr_valid, bus.ir_valid, bus.overflow}), 64'h0);
    @(negedge jtag_clk_i);
    rst_n = 1'b1;

    // 8-bit DR scan from the table
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].tms, tbl[i].tdi, tbl[i].tdo);
      chk($sformatf("tbl%0d_state", i), 64'(bus.tap_state), 64'(tbl[i].st));
      chk($sformatf("tbl%0d_dv", i), 64'(bus.dr_valid), 64'(tbl[i].dv));
    end
    chk("dr8_len", 64'(bus.dr_len), 64'd8);
    chk("dr8_tdi", bus.dr_tdi, 64'hA5);
    chk("dr8_tdo", bus.dr_tdo, 64'h3C);
    chk("dr8_ovf", 64'(bus.overflow), 64'h0);

    // IR scan of 4'b0100
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("ir_shift_state", 64'(bus.tap_state), 64'hA);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("ir_ex1_state", 64'(bus.tap_state), 64'h9);
    step(1, 0, 0);
    chk("ir_upd_state", 64'(bus.tap_state), 64'hD);
    chk("ir_valid_hi", 64'(bus.ir_valid), 64'h1);
    chk("ir_value", 64'(bus.ir_value), 64'h4);
    step(0, 0, 0);
    chk("ir_valid_lo", 64'(bus.ir_valid), 64'h0);

    // Pause and resume: 1,0,1,1 then 1,1,0,0
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    chk("pau_state", 64'(bus.tap_state), 64'h3);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("ex2_state", 64'(bus.tap_state), 64'h0);
    step(0, 0, 0);
    chk("resume_state", 64'(bus.tap_state), 64'h2);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("pau_dv", 64'(bus.dr_valid), 64'h1);
    chk("pau_len", 64'(bus.dr_len), 64'd8);
    chk("pau_tdi", bus.dr_tdi, 64'h3D);
    step(0, 0, 0);

    // Overflow: 70 ones into a 64-bit capture
    scan_dr(ones, 128'h0, 70, 1'b1);
    chk("ovf_len", 64'(bus.dr_len), 64'd64);
    chk("ovf_tdi", bus.dr_tdi, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ovf_flag", 64'(bus.overflow), 64'h1);
    scan_dr(128'hA5, 128'h3C, 8, 1'b1);
    chk("ovf_clr", 64'(bus.overflow), 64'h0);
    chk("ovf_clr_len", 64'(bus.dr_len), 64'd8);

    // cap_en=0: outputs hold
    bus.cap_en = 1'b0;
    scan_dr(128'h5A, 128'h0, 8, 1'b0);
    chk("capen_tdi_hold", bus.dr_tdi, 64'hA5);
    bus.cap_en = 1'b1;

    // trstn mid-scan after 5 bits
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 1);
    @(negedge jtag_clk_i);
    bus.trstn = 1'b0;
    bus.tms   = 1'b1;
    @(posedge jtag_clk_i);
    #1;
    chk("trst_state", 64'(bus.tap_state), 64'hF);
    chk("trst_dv", 64'(bus.dr_valid), 64'h0);
    chk("trst_ir", 64'(bus.ir_value), 64'h2);
    chk("trst_tdi_kept", bus.dr_tdi, 64'hA5);
    @(negedge jtag_clk_i);
    bus.trstn = 1'b1;
    step(0, 0, 0);
    chk("trst_rti", 64'(bus.tap_state), 64'hC);

    // Five tms=1 from ShIR walks to TLR via Update-IR
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("tlr5_s1", 64'(bus.tap_state), 64'h9);
    step(1, 0, 0);
    chk("tlr5_s2", 64'(bus.tap_state), 64'hD);
    chk("tlr5_ir_upd", 64'(bus.ir_value), 64'h6);
    step(1, 0, 0);
    chk("tlr5_s3", 64'(bus.tap_state), 64'h7);
    step(1, 0, 0);
    chk("tlr5_s4", 64'(bus.tap_state), 64'h4);
    step(1, 0, 0);
    chk("tlr5_tlr", 64'(bus.tap_state), 64'hF);
    chk("tlr5_no_irv", 64'(bus.ir_valid), 64'h0);
    chk("tlr5_ir_rst", 64'(bus.ir_value), 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_tdo_capture.md
Name: jtag_tdo_capture

Overview:
- Passive JTAG monitor downstream of the stimulus generator.
- Replays the IEEE 1149.1 TAP state machine from the generator's trstn/tms/tdi and samples the chip's tdo.
- Reconstructs each completed IR and DR scan: TDI word, TDO word and bit count, presented with a one-cycle valid pulse at Update.
- Gives the FPGA chip-test harness read-back data and a live TAP-state view without touching the JTAG pins.

Parameters:
- DR_MAX_W, 64: capacity of the DR capture registers in bits.
- IR_W, 4: instruction register length in bits.
- IR_RESET, 4'b0010: ir_value loaded on reset and on entry to Test-Logic-Reset.

Ports:
- jtag_clk_i  input  1  JTAG TCK; all sampling on its rising edge.
- rst_n  input  1  Reset; asynchronous, active-low.
- trstn  input  1  JTAG TRST from the generator, active-low, sampled synchronously.
- tms  input  1  JTAG TMS from the generator.
- tdi  input  1  JTAG TDI from the generator.
- tdo  input  1  JTAG TDO from the chip.
- cap_en  input  1  Enables DR capture and dr_valid; TAP tracking always runs.
- tap_state  output  4  Current TAP state, IEEE encoding.
- ir_value  output  IR_W  Last IR updated.
- ir_valid  output  1  One-cycle pulse in the Update-IR cycle.
- dr_tdi  output  DR_MAX_W  TDI bits of the last DR scan; bit 0 is the first bit shifted.
- dr_tdo  output  DR_MAX_W  TDO bits of the last DR scan, same ordering.
- dr_len  output  7  Bits shifted in the last DR scan, saturating at DR_MAX_W.
- dr_valid  output  1  One-cycle pulse in the Update-DR cycle.
- overflow  output  1  Sticky: the last DR scan exceeded DR_MAX_W bits.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - tap_state=4'hF (TLR), ir_value=IR_RESET.
  - dr_tdi, dr_tdo and dr_len = 0.
  - ir_valid, dr_valid and overflow = 0.
  - Internal shift registers and bit counter cleared.
- State encoding:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5.
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
- Transitions: standard 1149.1 graph on each posedge, using sampled tms.
- trstn=0 at a posedge:
  - Next tap_state=TLR, ir_value=IR_RESET, counter and shift registers cleared.
  - No valid pulse. Overrides tms.
- Entering TLR by five tms=1 gives the same ir_value and clear effects.
- CapDR cycle: DR counter and shift registers cleared.
- ShDR cycle (posedge while tap_state==ShDR, including the exit edge with tms=1):
  - If count<DR_MAX_W: sh_tdi[count]<=tdi, sh_tdo[count]<=tdo, count++.
  - Otherwise the bit is dropped and ovf_int<=1.
  - ovf_int is cleared at CapDR.
- Pause: PauDR and Ex2DR preserve the counter and shift registers. A return to ShDR continues appending.
- UpdDR (posedge where next state is UpdDR, cap_en=1):
  - dr_tdi, dr_tdo, dr_len and overflow load from the shift registers, count and ovf_int.
  - dr_valid=1 for exactly the one cycle tap_state==UpdDR.
- cap_en=0: DR outputs hold, dr_valid stays 0, shifting still occurs.
- IR path:
  - CapIR clears an IR_W shift register.
  - Each ShIR cycle shifts right with tdi into the MSB. Extra bits push out the oldest, so the last IR_W bits are kept.
  - UpdIR loads ir_value; ir_valid=1 for one cycle.
  - IR capture ignores cap_en.
- Latency:
  - tap_state reflects tms one edge after sampling.
  - Valid pulses coincide with the Update state cycle.
  - Outputs are stable until the next Update.
- Simultaneous events:
  - rst_n dominates trstn, which dominates tms.
  - A dr_valid/ir_valid pulse is cancelled if trstn=0 on that edge.
- Reset mid-scan discards partial data; previously latched DR outputs are cleared by rst_n only, not by trstn.
- All registers are in the jtag_clk_i domain. There is no combinational path from inputs to outputs.

Test Plan:
- DR scan of 8 bits:
  - Stimulus: rst_n release, then tms 0,1,0,0 (RTI→SelDR→CapDR→ShDR). Shift tdi=0xA5 LSB first with tms=1 on the 8th bit, tdo=0x3C. Then tms=1.
  - Required: dr_valid pulses once at tap_state=5, dr_len=8, dr_tdi=0xA5, dr_tdo=0x3C, overflow=0.
- IR scan:
  - Stimulus: tms 1,1,0,0 from RTI, then shift 4'b0100 LSB first, exit, update.
  - Required: ir_valid pulse at tap_state=D, ir_value=4'b0100.
- Pause/resume:
  - Stimulus: shift 4 bits 1,0,1,1. Ex1DR, PauDR×3, Ex2DR, back to ShDR. Shift 1,1,0,0. Update.
  - Required: dr_len=8, dr_tdi=8'h3D.
- Overflow:
  - Stimulus: shift 70 bits of tdi=1 with DR_MAX_W=64.
  - Required: dr_len=64, dr_tdi=all ones, overflow=1. The next 8-bit scan clears overflow to 0.
- Reset paths:
  - Stimulus 1: trstn=0 during ShDR after 5 bits. Required: tap_state=F next cycle, no dr_valid, ir_value=IR_RESET, prior dr_tdi unchanged.
  - Stimulus 2: five tms=1 from ShIR. Required: TLR, no ir_valid.
- cap_en=0: a DR scan of 0x5A updates tap_state normally; dr_valid stays 0 and dr_tdi keeps its old value.
